conv5x5_window_ctrl: RTL
========================

Name: conv5x5_window_ctrl

Overview:
- Sequencer for the 5x5 convolution datapath (line buffer, 5x5 window registers, 25-way signed multiplier array).
- Loads the 25 signed 8-bit filter taps serially into a held 200-bit filter word.
- Accepts a raster pixel stream with valid/ready, drives line-buffer address and window shift enables, and flags cycles where the window holds a valid convolution position.
- Sits between the pixel source and the line-buffer/multiplier stage, one instance per conv channel.

Parameters:
- IMG_W, 28, image width in pixels (>=5).
- IMG_H, 28, image height in pixels (>=5).
- COL_W, $clog2(IMG_W), column counter / line-buffer address width.
- ROW_W, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins operation, honoured only in IDLE.
- load_filter  in  1  sampled with start: 1 = load filter first, 0 = stream with the held filter.
- flt_valid  in  1  filter byte valid.
- flt_data  in  8  signed filter tap.
- flt_ready  out  1  high in LOAD.
- pix_valid  in  1  pixel stream valid.
- pix_ready  out  1  pixel accept.
- out_ready  in  1  downstream (adder tree) can take a window result.
- shift_en  out  1  advance window registers and line buffer this cycle.
- lb_addr  out  COL_W  line-buffer column address (current col).
- filter  out  200  held taps, tap i at [8i+7:8i], row-major (tap = 5*r + c).
- win_valid  out  1  registered; window regs hold a valid 5x5 position.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: state=IDLE; col, row, tap_cnt, filter, win_valid, done = 0. Reset mid-frame or mid-load discards all progress; filter returns to 0.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: start & load_filter -> LOAD (tap_cnt=0); start & !load_filter -> STREAM (col=row=0).
- LOAD:
  - flt_ready=1. Each flt_valid cycle writes flt_data to tap tap_cnt and increments tap_cnt.
  - The write at tap_cnt=24 -> STREAM (col=row=0).
  - Taps not rewritten keep their prior values until written.
- STREAM:
  - pix_ready = out_ready. accept = pix_valid & pix_ready; shift_en = accept (combinational); lb_addr = col.
  - On accept: col++. At col=IMG_W-1, col wraps to 0 and row++.
  - Accept of (row=IMG_H-1, col=IMG_W-1) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. Filter is retained for the next frame.
- win_valid (latency 1):
  - Next-cycle value = accept & (row>=4) & (col>=4), using the counters before increment.
  - Cleared otherwise, including on exiting STREAM.
  - Per frame: (IMG_W-4)*(IMG_H-4) assertions.
- Backpressure: out_ready=0 stalls acceptance, so counters hold and shift_en=0. win_valid still deasserts the next cycle, so it is never held across a stall.
- start while not IDLE is ignored. pix_valid outside STREAM is ignored (pix_ready=0). flt_valid outside LOAD is ignored.
- Multiplier product width is outside this block; the filter word is passed through unchanged.

Decomposition:
- Shared package (conv_pkg):
  - KSIZE=5, NTAPS=25, TAP_W=8, FILTER_W=200.
  - State enum {IDLE, LOAD, STREAM, DONE}.
- Natural sub-module: conv5x5_raster_cnt, holding the col/row counters with wrap, last-pixel and in-window flags, enabled by accept.
- The FSM and filter register stay in the top module.

Test Plan:
- Filter load: start+load_filter=1, bytes 1..25 with flt_valid gaps -> filter[7:0]=1, filter[199:192]=25. STREAM is entered the cycle after byte 25, with flt_ready low from then on.
- Full frame 28x28 with pix_valid=out_ready=1 every cycle:
  - First win_valid is one cycle after accept of (row4, col4), i.e. pixel index 116.
  - 576 win_valid pulses in total.
  - done pulses one cycle after pixel 783 is accepted.
  - busy then drops.
- Row wrap: pixels at col 27 -> lb_addr 27 then 0, row increments. No win_valid for cols 0..3 of any row.
- Backpressure: out_ready=0 for 3 cycles mid-row 10 -> pix_ready=0, shift_en=0, col unchanged, win_valid=0. Streaming resumes with no lost or duplicated win_valid (total still 576).
- Reuse filter: second start with load_filter=0 -> goes straight to STREAM, filter unchanged, same 576 windows. A start asserted mid-frame is ignored.
- Async reset: drop rst_n at pixel 300 -> all outputs 0 immediately, state IDLE, filter=0. A new load+frame after release completes normally.

Source files
------------

// File: rtl/conv5x5_window_ctrl_pkg.sv
// Shared constants and FSM state type for the 5x5 convolution window sequencer.
package conv_pkg;
  localparam int unsigned KSIZE    = 5;
  localparam int unsigned NTAPS    = KSIZE * KSIZE;
  localparam int unsigned TAP_W    = 8;
  localparam int unsigned FILTER_W = NTAPS * TAP_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StDone
  } state_e;
endpackage

// File: rtl/conv5x5_window_ctrl_if.sv
// Filter-load and pixel-stream handshake bundle between source, sequencer and datapath.
interface conv5x5_window_ctrl_if #(
  parameter int unsigned IMG_W = 28
);
  localparam int unsigned COL_W = $clog2(IMG_W);

  logic             flt_valid;
  logic [7:0]       flt_data;
  logic             flt_ready;
  logic             pix_valid;
  logic             pix_ready;
  logic             out_ready;
  logic             shift_en;
  logic [COL_W-1:0] lb_addr;
  logic             win_valid;

  modport master (
    output flt_valid, flt_data, pix_valid, out_ready,
    input  flt_ready, pix_ready, shift_en, lb_addr, win_valid
  );

  modport slave (
    input  flt_valid, flt_data, pix_valid, out_ready,
    output flt_ready, pix_ready, shift_en, lb_addr, win_valid
  );
endinterface

// File: rtl/conv5x5_raster_cnt.sv
// Raster column/row counters with frame wrap, last-pixel and in-window flags.
module conv5x5_raster_cnt
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned COL_W = $clog2(IMG_W),
  parameter int unsigned ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o,
  output logic             in_win_o
);
  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] ColWin  = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] RowWin  = ROW_W'(KSIZE - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_q == ColLast) begin
        col_d = '0;
        // Wrapping the row too leaves the counters clean for the next frame.
        row_d = (row_q == RowLast) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o    = col_q;
  assign row_o    = row_q;
  assign last_o   = (col_q == ColLast) && (row_q == RowLast);
  assign in_win_o = (row_q >= RowWin) && (col_q >= ColWin);
endmodule

// File: rtl/conv5x5_window_ctrl.sv
// Sequencer for the 5x5 conv datapath: serial filter load, raster stream control, window flag.
module conv5x5_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned COL_W = $clog2(IMG_W),
  parameter int unsigned ROW_W = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                load_filter_i,
  conv5x5_window_ctrl_if.slave bus,
  output logic [FILTER_W-1:0] filter_o,
  output logic                busy_o,
  output logic                done_o
);
  localparam int unsigned TapCntW = $clog2(NTAPS);
  localparam logic [TapCntW-1:0] LastTap = TapCntW'(NTAPS - 1);

  state_e               state_q, state_d;
  logic [TapCntW-1:0]   tap_cnt_q, tap_cnt_d;
  logic [FILTER_W-1:0]  filter_q, filter_d;
  logic                 win_valid_q, win_valid_d;
  logic                 pix_ready, accept, cnt_clr, last_pix, in_win;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;

  assign pix_ready = (state_q == StStream) && bus.out_ready;
  assign accept    = pix_ready && bus.pix_valid;

  conv5x5_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_raster_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (accept),
    .col_o    (col),
    .row_o    (row),
    .last_o   (last_pix),
    .in_win_o (in_win)
  );

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    filter_d  = filter_q;
    cnt_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (load_filter_i) begin
            state_d   = StLoad;
            tap_cnt_d = '0;
          end else begin
            state_d = StStream;
            cnt_clr = 1'b1;
          end
        end
      end
      StLoad: begin
        if (bus.flt_valid) begin
          filter_d[TAP_W*tap_cnt_q +: TAP_W] = bus.flt_data;
          if (tap_cnt_q == LastTap) begin
            state_d   = StStream;
            tap_cnt_d = '0;
            cnt_clr   = 1'b1;
          end else begin
            tap_cnt_d = tap_cnt_q + TapCntW'(1);
          end
        end
      end
      StStream: begin
        if (accept && last_pix) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Window flag follows only the accept of this cycle, so it drops on any stall.
  assign win_valid_d = accept && in_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tap_cnt_q   <= '0;
      filter_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      filter_q    <= filter_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign bus.flt_ready = (state_q == StLoad);
  assign bus.pix_ready = pix_ready;
  assign bus.shift_en  = accept;
  assign bus.lb_addr   = col;
  assign bus.win_valid = win_valid_q;
  assign filter_o      = filter_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
endmodule
